// File: rtl/j_mac_accum.sv
// j_mac_accum: 40-bit signed accumulator for the DSP multiply/accumulate path.
// Products (16- or 32-bit signed) are sign-extended into 8 guard bits, then a
// two-stage pipeline applies LOAD / ADD / SUB / CLEAR to the accumulator.
//
// Ports:
//   clk        in   system clock, rising edge
//   resetl     in   asynchronous active-low reset
//   in_valid   in   operation request valid
//   in_ready   out  block can accept (combinational, ~stall)
//   stall      in   DSP pipeline hold, freezes both stages
//   op[1:0]    in   00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
//   satszp     in   operand size: 0 = d[15:0], 1 = d[31:0]
//   d[31:0]    in   signed operand (multiplier product)
//   acc_q[39:0] out accumulator state ([31:0] data, [39:32] guard bits)
//   acc_valid  out  one-cycle pulse after the accumulator is written
//   ovf        out  sticky 40-bit signed-overflow flag
module j_mac_accum (
    input  logic        clk,
    input  logic        resetl,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        stall,
    input  logic [1:0]  op,
    input  logic        satszp,
    input  logic [31:0] d,
    output logic [39:0] acc_q,
    output logic        acc_valid,
    output logic        ovf
);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    // Sign-extend the operand into the 40-bit accumulator domain.
    function automatic logic [39:0] sign_ext(input logic sz, input logic [31:0] v);
        logic [39:0] r;
        if (sz) begin
            r = {{8{v[31]}}, v};
        end else begin
            r = {{24{v[15]}}, v[15:0]};
        end
        return r;
    endfunction

    // Signed overflow of a + b: operands agree in sign, result disagrees.
    function automatic logic add_ovf(input logic [39:0] a, input logic [39:0] b,
                                     input logic [39:0] r);
        return (a[39] == b[39]) && (r[39] != a[39]);
    endfunction

    // Signed overflow of a - b: operands differ in sign, result leaves a's sign.
    function automatic logic sub_ovf(input logic [39:0] a, input logic [39:0] b,
                                     input logic [39:0] r);
        return (a[39] != b[39]) && (r[39] != a[39]);
    endfunction

    logic [39:0] s1_ext_r;
    op_e         s1_op_r;
    logic        s1_v_r;
    logic [39:0] acc_r;
    logic        ovf_r;
    logic        acc_valid_r;

    logic [39:0] sum_s;
    logic [39:0] diff_s;
    logic [39:0] acc_nxt_s;
    logic        ovf_nxt_s;

    assign in_ready  = ~stall;
    assign acc_q     = acc_r;
    assign ovf       = ovf_r;
    assign acc_valid = acc_valid_r;

    // Stage 1: capture the extended operand and op on accept; bubble otherwise.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            s1_v_r   <= 1'b0;
            s1_ext_r <= 40'd0;
            s1_op_r  <= OP_LOAD;
        end else if (!stall) begin
            s1_v_r <= in_valid;
            if (in_valid) begin
                s1_ext_r <= sign_ext(satszp, d);
                s1_op_r  <= op_e'(op);
            end
        end
    end

    // Stage 2 datapath: next accumulator and sticky overflow from current state.
    always_comb begin
        sum_s     = acc_r + s1_ext_r;
        diff_s    = acc_r - s1_ext_r;
        acc_nxt_s = acc_r;
        ovf_nxt_s = ovf_r;
        case (s1_op_r)
            OP_LOAD: begin
                acc_nxt_s = s1_ext_r;
                ovf_nxt_s = 1'b0;
            end
            OP_ADD: begin
                acc_nxt_s = sum_s;
                if (add_ovf(acc_r, s1_ext_r, sum_s)) begin
                    ovf_nxt_s = 1'b1;
                end else begin
                    ovf_nxt_s = ovf_r;
                end
            end
            OP_SUB: begin
                acc_nxt_s = diff_s;
                if (sub_ovf(acc_r, s1_ext_r, diff_s)) begin
                    ovf_nxt_s = 1'b1;
                end else begin
                    ovf_nxt_s = ovf_r;
                end
            end
            OP_CLEAR: begin
                acc_nxt_s = 40'd0;
                ovf_nxt_s = 1'b0;
            end
            default: begin
                acc_nxt_s = acc_r;
                ovf_nxt_s = ovf_r;
            end
        endcase
    end

    // Stage 2 state: a pending stage-1 entry executes on the first unstalled edge.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            acc_r       <= 40'd0;
            ovf_r       <= 1'b0;
            acc_valid_r <= 1'b0;
        end else begin
            acc_valid_r <= s1_v_r & ~stall;
            if (s1_v_r && !stall) begin
                acc_r <= acc_nxt_s;
                ovf_r <= ovf_nxt_s;
            end
        end
    end

endmodule

// File: tb/tb_j_mac_accum.sv
// Directed self-checking bench for j_mac_accum with hand-computed expectations.
module tb_j_mac_accum;

    logic        clk = 1'b0;
    logic        resetl;
    logic        in_valid;
    logic        in_ready;
    logic        stall;
    logic [1:0]  op;
    logic        satszp;
    logic [31:0] d;
    logic [39:0] acc_q;
    logic        acc_valid;
    logic        ovf;

    int checks   = 0;
    int failures = 0;
    int vcount;

    localparam logic [1:0] LOAD  = 2'b00;
    localparam logic [1:0] ADD   = 2'b01;
    localparam logic [1:0] SUB   = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    j_mac_accum dut (
        .clk       (clk),
        .resetl    (resetl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stall     (stall),
        .op        (op),
        .satszp    (satszp),
        .d         (d),
        .acc_q     (acc_q),
        .acc_valid (acc_valid),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for one edge; returns 1 ns after that edge.
    task automatic drive(input logic [1:0] o, input logic sz, input logic [31:0] dv);
        in_valid = 1'b1;
        op       = o;
        satszp   = sz;
        d        = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetl   = 1'b0;
        in_valid = 1'b0;
        stall    = 1'b0;
        op       = 2'b00;
        satszp   = 1'b0;
        d        = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", acc_q, 40'd0);
        check("rst_ovf", {39'd0, ovf}, 40'd0);
        check("rst_valid", {39'd0, acc_valid}, 40'd0);
        check("rst_ready", {39'd0, in_ready}, 40'd1);
        resetl = 1'b1;
        idle();

        // 16-bit load/add; upper half of d ignored
        drive(LOAD, 1'b0, 32'h0000_8000);
        idle();
        check("ld16_acc", acc_q, 40'hFF_FFFF_8000);
        check("ld16_valid", {39'd0, acc_valid}, 40'd1);
        idle();
        check("ld16_valid_off", {39'd0, acc_valid}, 40'd0);
        drive(ADD, 1'b0, 32'hFFFF_7FFF);
        idle();
        check("add16_acc", acc_q, 40'hFF_FFFF_FFFF);
        check("add16_ovf", {39'd0, ovf}, 40'd0);
        check("add16_valid", {39'd0, acc_valid}, 40'd1);

        // 32-bit growth into guard bits
        drive(LOAD, 1'b1, 32'h7FFF_FFFF);
        drive(ADD, 1'b1, 32'h7FFF_FFFF);
        idle();
        check("add32_acc", acc_q, 40'h00_FFFF_FFFE);
        drive(SUB, 1'b1, 32'h8000_0000);
        idle();
        check("sub32_acc", acc_q, 40'h01_7FFF_FFFE);
        check("sub32_ovf", {39'd0, ovf}, 40'd0);

        // positive overflow: 257 * 0x7FFF_FFFF exceeds 2^39-1
        drive(CLEAR, 1'b0, 32'd0);
        for (int i = 0; i < 256; i++) drive(ADD, 1'b1, 32'h7FFF_FFFF);
        idle();
        check("addov_pre_acc", acc_q, 40'h7F_FFFF_FF00);
        check("addov_pre_ovf", {39'd0, ovf}, 40'd0);
        drive(ADD, 1'b1, 32'h7FFF_FFFF);
        idle();
        check("addov_acc", acc_q, 40'h80_7FFF_FEFF);
        check("addov_ovf", {39'd0, ovf}, 40'd1);
        drive(ADD, 1'b1, 32'h7FFF_FFFF);
        idle();
        check("addov_hold_acc", acc_q, 40'h80_FFFF_FEFE);
        check("addov_hold_ovf", {39'd0, ovf}, 40'd1);
        drive(CLEAR, 1'b1, 32'h1234_5678);
        idle();
        check("clr_acc", acc_q, 40'd0);
        check("clr_ovf", {39'd0, ovf}, 40'd0);

        // negative overflow through SUB, then LOAD clears the flag
        for (int i = 0; i < 256; i++) drive(SUB, 1'b1, 32'h7FFF_FFFF);
        idle();
        check("subov_pre_acc", acc_q, 40'h80_0000_0100);
        check("subov_pre_ovf", {39'd0, ovf}, 40'd0);
        drive(SUB, 1'b1, 32'h7FFF_FFFF);
        idle();
        check("subov_acc", acc_q, 40'h7F_8000_0101);
        check("subov_ovf", {39'd0, ovf}, 40'd1);
        drive(LOAD, 1'b0, 32'h0000_0005);
        idle();
        check("ld_clr_acc", acc_q, 40'd5);
        check("ld_clr_ovf", {39'd0, ovf}, 40'd0);

        // back-to-back stream of 8 ADDs
        drive(CLEAR, 1'b0, 32'd0);
        idle();
        idle();
        vcount = 0;
        for (int k = 1; k <= 8; k++) begin
            drive(ADD, 1'b0, 32'h0000_0001);
            if (acc_valid) vcount++;
            if (k == 4) check("stream_mid_acc", acc_q, 40'd3);
        end
        idle();
        if (acc_valid) vcount++;
        check("stream_acc", acc_q, 40'd8);
        check("stream_valid_cnt", 40'(vcount), 40'd8);
        idle();
        check("stream_valid_off", {39'd0, acc_valid}, 40'd0);

        // stall with an ADD pending in stage 1; a second request is refused
        drive(CLEAR, 1'b0, 32'd0);
        idle();
        idle();
        drive(ADD, 1'b0, 32'h0000_0007);
        stall = 1'b1;
        op    = ADD;
        d     = 32'h0000_0064;
        #1;
        check("stall_ready", {39'd0, in_ready}, 40'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("stall_acc", acc_q, 40'd0);
            check("stall_valid", {39'd0, acc_valid}, 40'd0);
        end
        stall    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("unstall_acc", acc_q, 40'd7);
        check("unstall_valid", {39'd0, acc_valid}, 40'd1);
        idle();
        idle();
        check("unstall_nodup", acc_q, 40'd7);

        // reset while an ADD sits in stage 1; create ovf first so reset has work
        drive(LOAD, 1'b1, 32'h7FFF_FFFF);
        for (int i = 0; i < 256; i++) drive(ADD, 1'b1, 32'h7FFF_FFFF);
        idle();
        check("prerst_ovf", {39'd0, ovf}, 40'd1);
        drive(ADD, 1'b0, 32'h0000_0005);
        in_valid = 1'b0;
        resetl   = 1'b0;
        #1;
        check("midrst_acc", acc_q, 40'd0);
        check("midrst_ovf", {39'd0, ovf}, 40'd0);
        check("midrst_valid", {39'd0, acc_valid}, 40'd0);
        @(posedge clk);
        #1;
        resetl = 1'b1;
        for (int c = 0; c < 3; c++) begin
            idle();
            check("postrst_valid", {39'd0, acc_valid}, 40'd0);
            check("postrst_acc", acc_q, 40'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
